// File: rtl/barker_pkg.sv
// barker_pkg: shared constants and types for the Barker-11 stream arbiter
package barker_pkg;
    localparam int BARKER_LEN = 11;
    localparam logic [BARKER_LEN-1:0] BARKER_SEQ = 11'b11100010010;
    typedef enum logic {S_IDLE, S_BUSY} arb_state_t;
endpackage

// File: rtl/barker_rr_pick.sv
// barker_rr_pick: combinational rotate-priority picker, first requester after ptr wins
module barker_rr_pick #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N_SRC-1:0] grant,
    output logic [SRC_W-1:0] idx,
    output logic             any
);
    // Walk from farthest to nearest offset so the nearest requester after ptr is kept.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        for (int i = N_SRC; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N_SRC]) begin
                grant = '0;
                grant[(int'(ptr) + i) % N_SRC] = 1'b1;
                idx = SRC_W'((int'(ptr) + i) % N_SRC);
            end
        end
    end
endmodule

// File: rtl/barker_stream_arbiter.sv
// barker_stream_arbiter: packet-atomic round-robin merge of 1-bit AXI streams
// into the Barker-11 correlator input, with per-grant beat limit.
module barker_stream_arbiter
    import barker_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int MAX_PKT_LEN = BARKER_LEN,
    parameter int SRC_W       = $clog2(N_SRC)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_src_en,
    input  logic [N_SRC-1:0] s_tdata,
    input  logic [N_SRC-1:0] s_tvalid,
    input  logic [N_SRC-1:0] s_tlast,
    output logic [N_SRC-1:0] s_tready,
    output logic             m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic [SRC_W-1:0] m_tid,
    input  logic             m_tready,
    output logic [N_SRC-1:0] o_grant,
    output logic             o_busy,
    output logic             o_len_err
);
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    arb_state_t       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] gidx_q, gidx_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q, m_tlast_d;
    logic [SRC_W-1:0] m_tid_q, m_tid_d;
    logic             len_err_q, len_err_d;

    logic [N_SRC-1:0] pick_grant;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_any;
    logic             ld, beat, ovr, g_valid, g_data, g_last;

    barker_rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_pick (
        .req   (s_tvalid & i_src_en),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign ld      = m_tready | ~m_tvalid_q;
    assign g_valid = |(s_tvalid & grant_q);
    assign g_data  = |(s_tdata & grant_q);
    assign g_last  = |(s_tlast & grant_q);
    assign beat    = (state_q == S_BUSY) & g_valid & ld;
    assign ovr     = cnt_q == CNT_W'(MAX_PKT_LEN - 1);

    // grant_q is all-zero outside S_BUSY, so ready needs no extra state term.
    assign s_tready  = grant_q & {N_SRC{ld}};
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign m_tid     = m_tid_q;
    assign o_grant   = grant_q;
    assign o_busy    = state_q == S_BUSY;
    assign o_len_err = len_err_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tready ? 1'b0 : m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        len_err_d  = 1'b0;
        if (state_q == S_IDLE && pick_any) begin
            state_d  = S_BUSY;
            grant_d  = pick_grant;
            gidx_d   = pick_idx;
            rr_ptr_d = pick_idx;
        end
        if (beat) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = g_data;
            m_tlast_d  = g_last | ovr;
            m_tid_d    = gidx_q;
            cnt_d      = g_last | ovr ? '0 : cnt_q + 1'b1;
            state_d    = g_last | ovr ? S_IDLE : S_BUSY;
            grant_d    = g_last | ovr ? '0 : grant_q;
            len_err_d  = ovr & ~g_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= SRC_W'(N_SRC - 1);
            cnt_q      <= '0;
            m_tdata_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
            len_err_q  <= len_err_d;
        end
    end
endmodule

// File: tb/tb_barker_stream_arbiter.sv
// tb_barker_stream_arbiter: directed checks of grant order, framing, overrun,
// masking, backpressure and async reset for the 4-source arbiter.
module tb_barker_stream_arbiter;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] i_src_en = 4'hF;
    logic [3:0] s_tdata = '0, s_tvalid = '0, s_tlast = '0;
    logic [3:0] s_tready;
    logic       m_tdata, m_tvalid, m_tlast;
    logic [1:0] m_tid;
    logic       m_tready = 1'b1;
    logic [3:0] o_grant;
    logic       o_busy, o_len_err;

    barker_stream_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src_en(i_src_en),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tready(m_tready), .o_grant(o_grant), .o_busy(o_busy), .o_len_err(o_len_err)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0, checks = 0;
    int cyc, first_v, first_m, len_err_n, len_err_cyc, stray_n, stall_n;
    bit rand_rdy;
    bit [31:0] sdat[4], slst[4];
    int slen[4], spos[4], start[4];
    int q_tid[$], q_cyc[$], gq[$];
    bit q_dat[$], q_lst[$];
    logic prev_stall;
    logic [4:0] prev_out;
    logic [3:0] prev_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input bit [31:0] bits, input bit [31:0] lasts, input int len, input int st);
        for (int k = 0; k < len; k++) begin
            sdat[i][k] = bits[len-1-k];
            slst[i][k] = lasts[len-1-k];
        end
        slen[i] = len;
        spos[i] = 0;
        start[i] = st;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        m_tready = 1'b1; i_src_en = 4'hF; rand_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin slen[i] = 0; spos[i] = 0; start[i] = 0; sdat[i] = '0; slst[i] = '0; end
        q_tid.delete(); q_cyc.delete(); q_dat.delete(); q_lst.delete(); gq.delete();
        cyc = 0; first_v = -1; first_m = -1; len_err_n = 0; len_err_cyc = -1;
        stray_n = 0; stall_n = 0; prev_stall = 1'b0; prev_out = '0; prev_grant = '0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // One cycle: drive at the falling edge, sample shortly after, then cross the rising edge.
    task automatic tick();
        bit [3:0] pop;
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i] = (cyc >= start[i]) && (spos[i] < slen[i]);
            s_tdata[i]  = (spos[i] < slen[i]) ? sdat[i][spos[i]] : 1'b0;
            s_tlast[i]  = (spos[i] < slen[i]) ? slst[i][spos[i]] : 1'b0;
        end
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (first_v < 0 && |s_tvalid) first_v = cyc;
        if (first_m < 0 && m_tvalid) first_m = cyc;
        if ((s_tready & ~o_grant) != 0 || $countones(s_tready) > 1) stray_n++;
        if (prev_stall && {m_tvalid, m_tdata, m_tlast, m_tid} !== prev_out) stall_n++;
        prev_stall = m_tvalid & ~m_tready;
        prev_out = {m_tvalid, m_tdata, m_tlast, m_tid};
        if (o_len_err) begin len_err_n++; len_err_cyc = cyc; end
        if (o_grant != 0 && o_grant != prev_grant)
            for (int j = 0; j < 4; j++) if (o_grant[j]) gq.push_back(j);
        prev_grant = o_grant;
        if (m_tvalid && m_tready) begin
            q_tid.push_back(int'(m_tid)); q_dat.push_back(m_tdata);
            q_lst.push_back(m_tlast); q_cyc.push_back(cyc);
        end
        pop = s_tvalid & s_tready;
        @(posedge i_clk);
        for (int i = 0; i < 4; i++) if (pop[i]) spos[i]++;
        cyc++;
        @(negedge i_clk);
    endtask

    function automatic bit [31:0] pack_dat(input int s);
        bit [31:0] v = '0;
        foreach (q_tid[k]) if (q_tid[k] == s) v = {v[30:0], q_dat[k]};
        return v;
    endfunction

    function automatic bit [31:0] pack_lst(input int s);
        bit [31:0] v = '0;
        foreach (q_tid[k]) if (q_tid[k] == s) v = {v[30:0], q_lst[k]};
        return v;
    endfunction

    function automatic bit [31:0] pack_gq();
        bit [31:0] v = '0;
        foreach (gq[k]) v = {v[27:0], 4'(gq[k])};
        return v;
    endfunction

    function automatic int count_tid(input int s);
        int n = 0;
        foreach (q_tid[k]) if (q_tid[k] == s) n++;
        return n;
    endfunction

    int interleave;
    bit [31:0] t2_dat[4] = '{32'h5A5, 32'h3C3, 32'h0F0, 32'h712};
    bit [31:0] t3_dat[4] = '{32'h2B4, 32'h19E, 32'h6D1, 32'h0A7};

    initial begin
        // reset state
        do_reset();
        tick();
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mout", {m_tdata, m_tlast, m_tid}, 0);
        check("rst_tready", s_tready, 0);
        check("rst_lenerr", o_len_err, 0);

        // single source, Barker-11 frame
        do_reset();
        load(0, 32'h712, 32'h001, 11, 0);
        repeat (20) tick();
        check("t1_n", q_tid.size(), 11);
        check("t1_data", pack_dat(0), 32'h712);
        check("t1_last", pack_lst(0), 32'h001);
        check("t1_tid0", count_tid(0), 11);
        check("t1_lat", first_m - first_v, 2);
        check("t1_lenerr", len_err_n, 0);

        // fairness: four back-to-back 11-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) load(i, t2_dat[i], 32'h001, 11, 0);
        repeat (60) tick();
        check("t2_n", q_tid.size(), 44);
        check("t2_order", pack_gq(), 32'h0123);
        check("t2_span", q_cyc[43] - q_cyc[0], 46);
        interleave = 0;
        foreach (q_tid[k]) if (q_tid[k] != k / 11) interleave++;
        check("t2_interleave", interleave, 0);
        for (int i = 0; i < 4; i++) check($sformatf("t2_data%0d", i), pack_dat(i), t2_dat[i]);

        // backpressure at 50% ready
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 4; i++) load(i, t3_dat[i], 32'h001, 11, 0);
        repeat (300) tick();
        check("t3_n", q_tid.size(), 44);
        for (int i = 0; i < 4; i++) check($sformatf("t3_data%0d", i), pack_dat(i), t3_dat[i]);
        check("t3_stall", stall_n, 0);
        check("t3_stray", stray_n, 0);

        // overrun: 15 beats without tlast on source 2
        do_reset();
        load(2, 32'h5A71, 32'h0, 15, 0);
        load(3, 32'h5, 32'h1, 3, 3);
        load(0, 32'h3, 32'h1, 3, 3);
        repeat (40) tick();
        check("t4_n", q_tid.size(), 21);
        check("t4_order", pack_gq(), 32'h2302);
        check("t4_data2", pack_dat(2), 32'h5A71);
        check("t4_last2", pack_lst(2), 32'h0010);
        check("t4_lenerr_n", len_err_n, 1);
        check("t4_lenerr_cyc", len_err_cyc, q_cyc[10]);
        check("t4_hold", {o_busy, o_grant}, 5'b10100);

        // mask: source 1 excluded, source 0 disabled mid-packet
        do_reset();
        i_src_en = 4'b1101;
        for (int i = 0; i < 4; i++) load(i, 32'h2D, 32'h09, 6, 0);
        for (int c = 0; c < 40; c++) begin
            if (c == 3) i_src_en = 4'b1100;
            tick();
        end
        check("t5_order", pack_gq(), 32'h02323);
        check("t5_src1", count_tid(1), 0);
        check("t5_src0", count_tid(0), 3);
        check("t5_last0", pack_lst(0), 32'h1);

        // async reset mid-packet
        do_reset();
        load(0, 32'h712, 32'h001, 11, 0);
        for (int c = 0; c < 50 && q_tid.size() < 5; c++) tick();
        check("t6_beats", q_tid.size(), 5);
        i_rst_n = 1'b0;
        #1;
        check("t6_rst_out", {m_tvalid, m_tdata, m_tlast, m_tid, o_len_err}, 0);
        check("t6_rst_ctl", {o_busy, o_grant, s_tready}, 0);
        do_reset();
        load(1, 32'h5, 32'h1, 3, 0);
        load(3, 32'h6, 32'h1, 3, 0);
        repeat (20) tick();
        check("t6_order", pack_gq(), 32'h13);
        check("t6_data1", pack_dat(1), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
